// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction RAM port, branch redirect, decode-side
// valid/ready handshake and fetch status. The master side is the fetch queue.
interface riscv_fetch_queue_if;
  logic [31:0] imem_index;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output imem_index,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    output halted,
    output fetch_count
  );

  modport slave (
    input  imem_index,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: walks instruction memory through a combinational
// RAM port, buffers {pc, instr} pairs in a small FIFO for the decode side, is
// flushed and restarted by branch redirects, and stops after fetching the EOF word.
module riscv_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IMEM_WORDS = 35,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EOF_WORD   = 32'hFFFF_FFFF
) (
  input logic            CLOCK_50,
  input logic            reset,
  riscv_fetch_queue_if.master bus
);

  localparam int unsigned       PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [31:0]       IMEM_LIMIT = 32'(IMEM_WORDS);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0]      fpc;
  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      fetch_total;

  // Queue storage holds data only; validity is tracked by count, so no reset.
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] word_mem [DEPTH];

  logic [31:0] word_idx;
  logic [31:0] fetch_word;
  logic [31:0] redirect_target;
  logic        in_range;
  logic        queue_nonempty;
  logic        pop;
  logic        push;

  // Words past the end of instruction memory (including fpc wrap) read as EOF.
  function automatic logic [31:0] bounded_word(input logic [31:0] rdata,
                                               input logic        hit);
    return hit ? rdata : EOF_WORD;
  endfunction

  assign word_idx        = {2'b00, fpc[31:2]};
  assign in_range        = (word_idx < IMEM_LIMIT);
  assign fetch_word      = bounded_word(bus.imem_rdata, in_range);
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
  assign queue_nonempty  = (count != '0);

  // A redirect discards the head rather than consuming it, and blocks the push.
  assign pop  = queue_nonempty && bus.instr_ready && !bus.redirect_valid;
  assign push = (state == ST_RUN) && !bus.redirect_valid && ((count < FULL_CNT) || pop);

  // Control state: fetch pointer, FSM, FIFO pointers/occupancy and fetch counter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_PC;
      state       <= ST_RUN;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fetch_total <= '0;
    end else if (bus.redirect_valid) begin
      fpc    <= redirect_target;
      state  <= ST_RUN;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fpc         <= fpc + 32'd4;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        fetch_total <= fetch_total + 32'd1;
        if (fetch_word == EOF_WORD) begin
          state <= ST_HALT;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write the fetched {pc, word} pair into the tail slot.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fpc;
      word_mem[wr_ptr] <= fetch_word;
    end
  end

  assign bus.imem_index  = word_idx;
  assign bus.instr_valid = queue_nonempty;
  assign bus.instr       = word_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];
  assign bus.halted      = (state == ST_HALT);
  assign bus.fetch_count = fetch_total;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and a randomized phase.
// A second instance with a two-word memory covers out-of-range fetch.
module tb_riscv_fetch_queue;

  localparam logic [31:0] EOF = 32'hFFFF_FFFF;
  localparam int          NW  = 35;

  logic CLOCK_50 = 1'b0;
  logic reset;

  riscv_fetch_queue_if bus ();
  riscv_fetch_queue_if bus2 ();

  riscv_fetch_queue #(.DEPTH(4), .IMEM_WORDS(NW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.master)
  );

  riscv_fetch_queue #(.DEPTH(4), .IMEM_WORDS(2)) dut2 (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus2.master)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [31:0] mem  [64];
  logic [31:0] mem2 [2];

  // Beyond the memory the RAM returns junk; the DUT must substitute EOF.
  assign bus.imem_rdata  = (bus.imem_index < 32'(NW)) ? mem[bus.imem_index[5:0]] : 32'hDEAD_BEEF;
  assign bus2.imem_rdata = (bus2.imem_index < 32'd2) ? mem2[bus2.imem_index[0]] : 32'h1234_5678;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain queue of {pc, word}, fetch address, halt flag, counter.
  logic [63:0] q[$];
  logic [31:0] m_fpc  = 32'h0;
  logic        m_halt = 1'b0;
  logic [31:0] m_fc   = 32'h0;

  initial begin
    logic        do_pop, do_push;
    logic [31:0] w, widx;
    forever begin
      @(posedge CLOCK_50 or posedge reset);
      if (reset) begin
        q.delete();
        m_fpc  = 32'h0;
        m_halt = 1'b0;
        m_fc   = 32'h0;
      end else if (bus.redirect_valid) begin
        q.delete();
        m_fpc  = {bus.redirect_pc[31:2], 2'b00};
        m_halt = 1'b0;
      end else begin
        do_pop  = (q.size() != 0) && bus.instr_ready;
        do_push = !m_halt && ((q.size() < 4) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          widx = m_fpc / 4;
          w    = (widx < NW) ? mem[widx[5:0]] : EOF;
          q.push_back({m_fpc, w});
          m_fpc = m_fpc + 4;
          m_fc  = m_fc + 1;
          if (w == EOF) m_halt = 1'b1;
        end
      end
    end
  end

  // Every falling edge: DUT outputs against the model.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      check("model_valid", {31'd0, bus.instr_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        check("model_pc", bus.instr_pc, q[0][63:32]);
        check("model_instr", bus.instr, q[0][31:0]);
      end
      check("model_halted", {31'd0, bus.halted}, {31'd0, m_halt});
      check("model_fetch_count", bus.fetch_count, m_fc);
      check("model_imem_index", bus.imem_index, m_fpc / 4);
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus2.instr_ready    = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 + 32'(i) * 32'h0010_0000;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;
    mem[4] = EOF;
    mem2[0] = 32'h0000_0013;
    mem2[1] = 32'h0010_0093;

    // Reset state
    tick();
    tick();
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_fetch_count", bus.fetch_count, 32'd0);
    reset = 1'b0;

    // Straight-line fetch with consumer always ready
    bus.instr_ready = 1'b1;
    tick();
    check("line_pc0", bus.instr_pc, 32'd0);
    check("line_instr0", bus.instr, 32'h0000_0013);
    tick(); check("line_pc4", bus.instr_pc, 32'd4);
    tick(); check("line_pc8", bus.instr_pc, 32'd8);
    tick(); check("line_pc12", bus.instr_pc, 32'd12);
    tick();
    check("line_pc16", bus.instr_pc, 32'd16);
    check("line_eof", bus.instr, EOF);
    check("line_halted", {31'd0, bus.halted}, 32'd1);
    check("line_fetch_count", bus.fetch_count, 32'd5);
    tick();
    check("line_drained", {31'd0, bus.instr_valid}, 32'd0);

    // Backpressure: queue fills to DEPTH, then pop and push share an edge
    bus.instr_ready = 1'b0;
    reset_pulse();
    repeat (10) tick();
    check("bp_fetch_count", bus.fetch_count, 32'd4);
    check("bp_head_pc", bus.instr_pc, 32'd0);
    check("bp_fpc_index", bus.imem_index, 32'd4);
    check("bp_not_halted", {31'd0, bus.halted}, 32'd0);
    bus.instr_ready = 1'b1;
    tick();
    check("bp_head_pc4", bus.instr_pc, 32'd4);
    check("bp_fetch_count5", bus.fetch_count, 32'd5);
    check("bp_halted", {31'd0, bus.halted}, 32'd1);
    repeat (5) tick();

    // Redirect with three entries queued, ready asserted in the redirect cycle
    bus.instr_ready = 1'b0;
    reset_pulse();
    repeat (3) tick();
    check("rd_fill_count", bus.fetch_count, 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0009;
    bus.instr_ready    = 1'b1;
    tick();
    check("rd_flushed", {31'd0, bus.instr_valid}, 32'd0);
    check("rd_fetch_count", bus.fetch_count, 32'd3);
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    tick();
    check("rd_head_pc", bus.instr_pc, 32'h8);
    check("rd_head_instr", bus.instr, 32'h0020_0113);

    // Run to HALT and drain, then redirect out of HALT
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.halted && !bus.instr_valid) break;
    end
    check("halt_reached", {31'd0, bus.halted}, 32'd1);
    check("halt_drained", {31'd0, bus.instr_valid}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0004;
    bus.instr_ready    = 1'b0;
    tick();
    check("unhalt_halted", {31'd0, bus.halted}, 32'd0);
    bus.redirect_valid = 1'b0;
    tick();
    check("unhalt_pc", bus.instr_pc, 32'd4);
    check("unhalt_valid", {31'd0, bus.instr_valid}, 32'd1);

    // Asynchronous reset between edges with a partially full queue
    tick();
    #2 reset = 1'b1;
    #1;
    check("areset_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("areset_halted", {31'd0, bus.halted}, 32'd0);
    check("areset_fetch_count", bus.fetch_count, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("areset_first_pc", bus.instr_pc, 32'h0);
    check("areset_first_valid", {31'd0, bus.instr_valid}, 32'd1);

    // Randomized traffic: random program, backpressure and redirects
    reset_pulse();
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? EOF : ($urandom & 32'hFFFF_FF7F);
    for (int c = 0; c < 800; c++) begin
      bus.instr_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 17) == 0);
      case ($urandom_range(0, 7))
        0:       bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       bus.redirect_pc = 32'd128 + 32'($urandom_range(0, 31));
        default: bus.redirect_pc = 32'($urandom_range(0, 150));
      endcase
      tick();
    end
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;

    // Out-of-range fetch on the two-word instance
    reset_pulse();
    repeat (4) tick();
    check("oor_halted", {31'd0, bus2.halted}, 32'd1);
    check("oor_fetch_count", bus2.fetch_count, 32'd3);
    check("oor_head_pc", bus2.instr_pc, 32'd0);
    bus2.instr_ready = 1'b1;
    tick();
    check("oor_pc4", bus2.instr_pc, 32'd4);
    check("oor_instr1", bus2.instr, 32'h0010_0093);
    tick();
    check("oor_pc8", bus2.instr_pc, 32'd8);
    check("oor_eof", bus2.instr, EOF);
    tick();
    check("oor_drained", {31'd0, bus2.instr_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
